// File: rtl/accel_sequencer.sv
// accel_sequencer: top-level layer sequencer for the tensor accelerator.
// Fetches a four-word layer descriptor from the parameter SRAM, publishes the
// decoded configuration on registered outputs, then launches the compute
// engine once per tile with a start/done handshake and pulses finish_o at the
// end of the layer. The control outputs are decoded from the state register,
// so they drop as soon as rstn is asserted.
module accel_sequencer #(
    parameter int PARAM_WORDS = 4,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_i,
    input  logic [3:0]        mode_i,
    output logic              finish_o,
    output logic              busy_o,
    output logic              param_cs_o,
    output logic              param_oe_o,
    output logic [1:0]        param_addr_o,
    input  logic [DATA_W-1:0] param_do_i,
    output logic [3:0]        cfg_mode_o,
    output logic [15:0]       cfg_in_ch_o,
    output logic [15:0]       cfg_out_ch_o,
    output logic [15:0]       cfg_height_o,
    output logic [15:0]       cfg_width_o,
    output logic [7:0]        cfg_kernel_o,
    output logic [7:0]        cfg_stride_o,
    output logic [7:0]        cfg_pad_o,
    output logic [15:0]       cfg_tiles_o,
    output logic              eng_start_o,
    output logic [15:0]       eng_tile_o,
    input  logic              eng_done_i
);

    // Address of the final descriptor word; the fetch ends after issuing it.
    localparam logic [1:0] LAST_ADDR = 2'(PARAM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAP,
        S_LAUNCH,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    // Read issue counter and the one-cycle read-data valid pipe.
    logic [1:0]        rd_cnt_q;
    logic              vld_q;
    logic [1:0]        vld_idx_q;

    // Descriptor words 0..2; word 3 is consumed straight off the SRAM bus
    // during CAP so all config fields can be published on one edge.
    logic [DATA_W-1:0] word0_q;
    logic [DATA_W-1:0] word1_q;
    logic [DATA_W-1:0] word2_q;

    logic [15:0]       tile_q;
    logic              tile_last;
    logic              start_accept;
    logic              unused_bits;

    assign start_accept = (state_q == S_IDLE) && start_i;
    assign tile_last    = (tile_q == (cfg_tiles_o - 16'd1));
    assign busy_o       = (state_q != S_IDLE);
    assign eng_tile_o   = tile_q;

    // Reserved descriptor bits are read but never used.
    assign unused_bits  = ^word2_q[7:0];

    // State register; reset aborts any operation in progress.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and decoded control outputs.
    always_comb begin
        state_d      = state_q;
        finish_o     = 1'b0;
        param_cs_o   = 1'b0;
        param_oe_o   = 1'b0;
        param_addr_o = '0;
        eng_start_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    // Mode 0 is a no-op layer: skip the fetch entirely.
                    state_d = (mode_i != 4'd0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                param_cs_o   = 1'b1;
                param_oe_o   = 1'b1;
                param_addr_o = rd_cnt_q;
                if (rd_cnt_q == LAST_ADDR) begin
                    state_d = S_CAP;
                end
            end
            S_CAP: begin
                // Word 3 is on the bus now; its low half is the tile count.
                state_d = (param_do_i[15:0] == 16'd0) ? S_DONE : S_LAUNCH;
            end
            S_LAUNCH: begin
                eng_start_o = 1'b1;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done_i) begin
                    state_d = tile_last ? S_DONE : S_LAUNCH;
                end
            end
            S_DONE: begin
                finish_o = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Read issue counter and the valid pipe tracking which word is returning.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_cnt_q  <= '0;
            vld_q     <= 1'b0;
            vld_idx_q <= '0;
        end else begin
            if (start_accept) begin
                rd_cnt_q <= '0;
            end else if (state_q == S_FETCH) begin
                rd_cnt_q <= rd_cnt_q + 2'd1;
            end
            vld_q     <= (state_q == S_FETCH);
            vld_idx_q <= rd_cnt_q;
        end
    end

    // Capture returning descriptor words 0..2 one cycle after each issue.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            word0_q <= '0;
            word1_q <= '0;
            word2_q <= '0;
        end else if (vld_q) begin
            case (vld_idx_q)
                2'd0:    word0_q <= param_do_i;
                2'd1:    word1_q <= param_do_i;
                2'd2:    word2_q <= param_do_i;
                default: ;
            endcase
        end
    end

    // Configuration registers: mode on start acceptance, fields at CAP.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cfg_mode_o   <= '0;
            cfg_in_ch_o  <= '0;
            cfg_out_ch_o <= '0;
            cfg_height_o <= '0;
            cfg_width_o  <= '0;
            cfg_kernel_o <= '0;
            cfg_stride_o <= '0;
            cfg_pad_o    <= '0;
            cfg_tiles_o  <= '0;
        end else begin
            if (start_accept) begin
                cfg_mode_o <= mode_i;
            end
            if (state_q == S_CAP) begin
                cfg_in_ch_o  <= word0_q[31:16];
                cfg_out_ch_o <= word0_q[15:0];
                cfg_height_o <= word1_q[31:16];
                cfg_width_o  <= word1_q[15:0];
                cfg_kernel_o <= word2_q[31:24];
                cfg_stride_o <= word2_q[23:16];
                cfg_pad_o    <= word2_q[15:8];
                cfg_tiles_o  <= param_do_i[15:0];
            end
        end
    end

    // Tile index: cleared at CAP, advanced on each non-final engine done.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tile_q <= '0;
        end else if (state_q == S_CAP) begin
            tile_q <= '0;
        end else if ((state_q == S_WAIT) && eng_done_i && !tile_last) begin
            tile_q <= tile_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_accel_sequencer.sv
// Testbench for accel_sequencer: directed and randomized layers checked
// cycle by cycle against a timeline computed from the descriptor, mode and
// chosen engine latencies.
module tb_accel_sequencer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start_i = 1'b0;
    logic [3:0]  mode_i = '0;
    logic        eng_done_i = 1'b0;
    logic [31:0] param_do_i = '0;

    logic        finish_o, busy_o, param_cs_o, param_oe_o, eng_start_o;
    logic [1:0]  param_addr_o;
    logic [3:0]  cfg_mode_o;
    logic [15:0] cfg_in_ch_o, cfg_out_ch_o, cfg_height_o, cfg_width_o;
    logic [15:0] cfg_tiles_o, eng_tile_o;
    logic [7:0]  cfg_kernel_o, cfg_stride_o, cfg_pad_o;

    int n_assert = 0;
    int n_fail   = 0;

    // Expected configuration register contents.
    logic [3:0]  e_mode;
    logic [15:0] e_in, e_out, e_h, e_w, e_tiles;
    logic [7:0]  e_k, e_s, e_p;

    logic [31:0] mem [4];

    accel_sequencer #(.PARAM_WORDS(4), .DATA_W(32)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start_i      (start_i),
        .mode_i       (mode_i),
        .finish_o     (finish_o),
        .busy_o       (busy_o),
        .param_cs_o   (param_cs_o),
        .param_oe_o   (param_oe_o),
        .param_addr_o (param_addr_o),
        .param_do_i   (param_do_i),
        .cfg_mode_o   (cfg_mode_o),
        .cfg_in_ch_o  (cfg_in_ch_o),
        .cfg_out_ch_o (cfg_out_ch_o),
        .cfg_height_o (cfg_height_o),
        .cfg_width_o  (cfg_width_o),
        .cfg_kernel_o (cfg_kernel_o),
        .cfg_stride_o (cfg_stride_o),
        .cfg_pad_o    (cfg_pad_o),
        .cfg_tiles_o  (cfg_tiles_o),
        .eng_start_o  (eng_start_o),
        .eng_tile_o   (eng_tile_o),
        .eng_done_i   (eng_done_i)
    );

    always #5 clk = ~clk;

    // Parameter SRAM: data one cycle after a read, garbage otherwise.
    always @(posedge clk) begin
        if (param_cs_o && param_oe_o) param_do_i <= mem[param_addr_o];
        else                          param_do_i <= $urandom();
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cfg(input string tag);
        check({tag, ".mode"},   32'(cfg_mode_o),   32'(e_mode));
        check({tag, ".in_ch"},  32'(cfg_in_ch_o),  32'(e_in));
        check({tag, ".out_ch"}, 32'(cfg_out_ch_o), 32'(e_out));
        check({tag, ".height"}, 32'(cfg_height_o), 32'(e_h));
        check({tag, ".width"},  32'(cfg_width_o),  32'(e_w));
        check({tag, ".kernel"}, 32'(cfg_kernel_o), 32'(e_k));
        check({tag, ".stride"}, 32'(cfg_stride_o), 32'(e_s));
        check({tag, ".pad"},    32'(cfg_pad_o),    32'(e_p));
        check({tag, ".tiles"},  32'(cfg_tiles_o),  32'(e_tiles));
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".busy"},   32'(busy_o),      32'd0);
        check({tag, ".cs"},     32'(param_cs_o),  32'd0);
        check({tag, ".oe"},     32'(param_oe_o),  32'd0);
        check({tag, ".start"},  32'(eng_start_o), 32'd0);
        check({tag, ".finish"}, 32'(finish_o),    32'd0);
    endtask

    task automatic clear_cfg_model();
        e_mode = '0; e_in = '0; e_out = '0; e_h = '0; e_w = '0;
        e_k = '0; e_s = '0; e_p = '0; e_tiles = '0;
    endtask

    // Run one layer. The expected timeline is built up front:
    // fetch in cycles 1-4, CAP in 5, first launch in 6, each done sampled
    // at the end of cycle launch+lat, next launch or finish the cycle after.
    // abort_tile >= 0 asserts reset one cycle into that tile's wait.
    task automatic run_layer(input string tag, input logic [3:0] m,
                             input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3,
                             input int lat_min, input int lat_max,
                             input bit abuse, input int abort_tile);
        bit   done_at [0:127];
        bit   st_at   [0:127];
        int   tile_at [0:127];
        int   launch_c [0:15];
        int   tiles, fin, c, lat, abort_c;
        mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3;
        tiles = int'(w3[15:0]);
        abort_c = -1;
        if (m == 4'd0) begin
            fin = 1;
        end else if (tiles == 0) begin
            fin = 6;
        end else begin
            c = 6;
            for (int i = 0; i < tiles; i++) begin
                st_at[c] = 1'b1;
                tile_at[c] = i;
                launch_c[i] = c;
                lat = int'($urandom_range(lat_max, lat_min));
                done_at[c + lat] = 1'b1;
                c = c + lat + 1;
            end
            fin = c;
            if (abort_tile >= 0) abort_c = launch_c[abort_tile] + 1;
        end

        // cycle 0: request the layer while idle
        check({tag, ".c0.busy"}, 32'(busy_o), 32'd0);
        check({tag, ".c0.finish"}, 32'(finish_o), 32'd0);
        start_i = 1'b1;
        mode_i  = m;
        tick();
        start_i = 1'b0;
        mode_i  = $urandom_range(15, 0);

        for (int cy = 1; cy <= fin; cy++) begin
            eng_done_i = done_at[cy] || (abuse && cy == 2);
            start_i    = abuse && (m != 4'd0) && (tiles > 0) && (cy == launch_c[0] + 1);
            check($sformatf("%s.c%0d.busy", tag, cy), 32'(busy_o), 32'd1);
            check($sformatf("%s.c%0d.cs", tag, cy), 32'(param_cs_o),
                  32'((m != 4'd0) && cy <= 4));
            check($sformatf("%s.c%0d.oe", tag, cy), 32'(param_oe_o),
                  32'((m != 4'd0) && cy <= 4));
            if ((m != 4'd0) && cy <= 4)
                check($sformatf("%s.c%0d.addr", tag, cy), 32'(param_addr_o), 32'(cy - 1));
            check($sformatf("%s.c%0d.eng_start", tag, cy), 32'(eng_start_o), 32'(st_at[cy]));
            if (st_at[cy])
                check($sformatf("%s.c%0d.tile", tag, cy), 32'(eng_tile_o), 32'(tile_at[cy]));
            check($sformatf("%s.c%0d.finish", tag, cy), 32'(finish_o), 32'(cy == fin));
            if (cy == abort_c) begin
                #2;
                rstn = 1'b0;
                #1;
                check_quiet({tag, ".rst"});
                check({tag, ".rst.addr"}, 32'(param_addr_o), 32'd0);
                check({tag, ".rst.tile"}, 32'(eng_tile_o), 32'd0);
                clear_cfg_model();
                check_cfg({tag, ".rst"});
                eng_done_i = 1'b0;
                start_i    = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    check({tag, ".rst.finish"}, 32'(finish_o), 32'd0);
                    check({tag, ".rst.busy"}, 32'(busy_o), 32'd0);
                end
                rstn = 1'b1;
                tick();
                return;
            end
            tick();
        end
        eng_done_i = 1'b0;
        start_i    = 1'b0;

        e_mode = m;
        if (m != 4'd0) begin
            e_in  = w0[31:16]; e_out = w0[15:0];
            e_h   = w1[31:16]; e_w   = w1[15:0];
            e_k   = w2[31:24]; e_s   = w2[23:16]; e_p = w2[15:8];
            e_tiles = w3[15:0];
        end
        check_cfg(tag);
    endtask

    initial begin
        logic [31:0] r0, r1, r2, r3;
        clear_cfg_model();

        // Reset then idle
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check_quiet("idle");
            check("idle.addr", 32'(param_addr_o), 32'd0);
            check("idle.tile", 32'(eng_tile_o), 32'd0);
            tick();
        end
        check_cfg("idle");

        // Basic layer
        run_layer("basic", 4'd2, 32'h0010_0020, 32'h0008_0008, 32'h0301_0100,
                  32'h0000_0003, 4, 4, 1'b0, -1);
        check("basic.in_ch",  32'(cfg_in_ch_o),  32'd16);
        check("basic.out_ch", 32'(cfg_out_ch_o), 32'd32);
        check("basic.height", 32'(cfg_height_o), 32'd8);
        check("basic.width",  32'(cfg_width_o),  32'd8);
        check("basic.kernel", 32'(cfg_kernel_o), 32'd3);
        check("basic.stride", 32'(cfg_stride_o), 32'd1);
        check("basic.pad",    32'(cfg_pad_o),    32'd1);
        check("basic.tiles",  32'(cfg_tiles_o),  32'd3);
        check("basic.mode",   32'(cfg_mode_o),   32'd2);

        // Zero tiles, reserved upper bits of word 3 set
        run_layer("zero", 4'd5, 32'h1111_2222, 32'h3333_4444, 32'h0502_03AA,
                  32'hABCD_0000, 1, 1, 1'b0, -1);

        // Mode 0: no fetch, only mode changes
        run_layer("mode0", 4'd0, $urandom(), $urandom(), $urandom(),
                  32'h0000_0002, 1, 1, 1'b0, -1);

        // Protocol abuse
        run_layer("abuse", 4'd7, $urandom(), $urandom(), $urandom(),
                  32'h0000_0003, 2, 5, 1'b1, -1);

        // Reset mid-wait on tile 1, then a clean re-run
        r0 = $urandom(); r1 = $urandom(); r2 = $urandom();
        run_layer("abort", 4'd3, r0, r1, r2, 32'h0000_0003, 3, 5, 1'b0, 1);
        run_layer("rerun", 4'd3, r0, r1, r2, 32'h0000_0003, 1, 3, 1'b0, -1);

        // Randomized layers
        for (int n = 0; n < 8; n++) begin
            r0 = $urandom(); r1 = $urandom(); r2 = $urandom();
            r3 = {16'($urandom()), 16'($urandom_range(4, 0))};
            run_layer($sformatf("rand%0d", n), 4'($urandom_range(15, 0)),
                      r0, r1, r2, r3, 1, 6, 1'($urandom_range(1, 0)), -1);
        end

        for (int i = 0; i < 3; i++) begin
            check_quiet("tail");
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/accel_sequencer.md
# accel_sequencer

Top-level control sequencer for the tensor accelerator. On a start pulse it latches the requested mode, fetches the 16-byte layer descriptor from the parameter SRAM (four 32-bit words), and drives the decoded configuration onto registered config outputs. It then runs the compute engine once per tile with a start/done handshake and pulses `finish_o` when the layer completes. It sits between the chip-level `start_i`/`mode_i`/`finish_o` pins and the accelerator datapath. It is the only master of the parameter SRAM port.

## Interface

- `PARAM_WORDS`, 4: descriptor length in words. Fixed to 4; other values are unsupported.
- `DATA_W`, 32: parameter SRAM word width.
- `clk` in 1: single clock. All logic is rising-edge.
- `rstn` in 1: reset, asynchronous assert, active-low.
- `start_i` in 1: start request. Sampled only in IDLE.
- `mode_i` in 4: layer mode. Latched with `start_i`.
- `finish_o` out 1: one-cycle pulse at layer completion.
- `busy_o` out 1: high in every state except IDLE.
- `param_cs_o` out 1: parameter SRAM chip select.
- `param_oe_o` out 1: parameter SRAM read enable.
- `param_addr_o` out 2: parameter SRAM word address.
- `param_do_i` in 32: parameter SRAM read data. Valid one cycle after `cs`/`oe`.
- `cfg_mode_o` out 4: latched mode.
- `cfg_in_ch_o` out 16: word0[31:16].
- `cfg_out_ch_o` out 16: word0[15:0].
- `cfg_height_o` out 16: word1[31:16].
- `cfg_width_o` out 16: word1[15:0].
- `cfg_kernel_o` out 8: word2[31:24].
- `cfg_stride_o` out 8: word2[23:16].
- `cfg_pad_o` out 8: word2[15:8].
- `cfg_tiles_o` out 16: word3[15:0], the tile count.
- `eng_start_o` out 1: one-cycle engine start pulse.
- `eng_tile_o` out 16: index of the current tile.
- `eng_done_i` in 1: engine completion pulse.

## Operation

- States: IDLE, FETCH, CAP, LAUNCH, WAIT, DONE.
- **IDLE**
  - `start_i`=1 with `mode_i`≠0: latch mode, clear the read counter, go to FETCH.
  - `start_i`=1 with `mode_i`=0: mode 0 is a no-op. Latch mode 0 and go straight to DONE. No SRAM access occurs and the cfg fields other than mode are unchanged.
- **FETCH** (4 cycles)
  - `param_cs_o`=`param_oe_o`=1 and `param_addr_o`=rd_cnt, for rd_cnt 0,1,2,3.
  - A one-bit valid pipe, delayed one cycle from each issue, captures `param_do_i` into word register rd_cnt−1.
  - After the issue at address 3, go to CAP.
- **CAP** (1 cycle)
  - `cs`/`oe`=0. Word3 is captured.
  - Clear the tile index to 0.
  - Tile count = 0 → DONE; otherwise → LAUNCH.
- **LAUNCH** (1 cycle): `eng_start_o`=1, `eng_tile_o`=tile index; then go to WAIT.
- **WAIT**: hold until `eng_done_i`=1.
  - tile index = tiles−1 → DONE.
  - Otherwise increment the tile index and go to LAUNCH.
- **DONE** (1 cycle): `finish_o`=1, then return to IDLE.
- Config outputs are registers. They update only at capture and hold their values until the next capture.
- `start_i` outside IDLE is ignored; it is not queued.
- `eng_done_i` outside WAIT is ignored.
- Reserved descriptor bits (word2[7:0], word3[31:16]) are discarded.
- The tile index is 16-bit. The maximum tile count is 65535, so the index never wraps.

## Timing

- Reset values: every output is 0 and the state is IDLE. Reset mid-operation aborts immediately.
  - `eng_start_o`, `finish_o`, `busy_o` and `param_cs_o` drop asynchronously.
  - No finish pulse is emitted.
  - The engine is not notified. Resetting the engine is the system's responsibility.
- Start is sampled at edge 0.
  - FETCH occupies cycles 1–4, with addresses 0–3.
  - Words are captured at edges 2–5.
  - CAP is cycle 5.
  - The first `eng_start_o` is in cycle 6.
  - `busy_o` is high from cycle 1.
- For a done sampled at edge t:
  - If more tiles remain: the next LAUNCH is in cycle t+1.
  - After the last tile: `finish_o` is in cycle t+1, `busy_o` goes low in cycle t+2, and a new start is accepted at edge t+2.
- A done in the same cycle as LAUNCH is not sampled. The minimum engine latency is 1 cycle after `eng_start_o`.
- Mode 0: start at edge 0 gives `finish_o` in cycle 1.
- Zero tiles: CAP in cycle 5, `finish_o` in cycle 6, no `eng_start_o`.

## Test plan

- Reset then idle:
  - Hold `start_i`=0 for 10 cycles.
  - Require all outputs 0 and no SRAM access.
- Basic layer:
  - Preload words 0x0010_0020, 0x0008_0008, 0x0301_0100, 0x0000_0003.
  - Start with mode 2. The engine returns done 4 cycles after each start.
  - Require addresses 0–3 in cycles 1–4.
  - Require in_ch=16, out_ch=32, h=w=8, k=3, s=1, pad=1, tiles=3.
  - Require `eng_start_o` with tiles 0,1,2, exactly one `finish_o`, and `cfg_mode_o`=2.
- Zero tiles: word3=0 → no `eng_start_o`, and `finish_o` exactly in cycle 6.
- Mode 0: require `finish_o` in cycle 1, no `param_cs_o`, and cfg unchanged.
- Protocol abuse:
  - Pulse `start_i` during WAIT and inject `eng_done_i` during FETCH.
  - Require no restart, no premature tile advance, and the normal sequence completing.
- Reset mid-WAIT:
  - Assert `rstn`=0 asynchronously while tile 1 is in progress.
  - Require outputs cleared immediately and no `finish_o`.
  - A fresh start after reset re-fetches the descriptor and completes normally.
